// File: rtl/mem_pkg.sv
// Shared encodings and lane-placement helper for the memory access unit.
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic {S_IDLE, S_RMW_WR} state_t;

   localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
   localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;
   localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFF;

   // Bit offset of the addressed lane inside the memory word.
   function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] off,
                                             input logic be);
      logic [1:0] lane;
      lane = off;
      if (size[1]) begin
         lane = 2'd0;
      end else if (be) begin
         lane = (size == SZ_BYTE) ? (2'd3 - off) : (2'd2 - off);
      end
      return {lane, 3'b000};
   endfunction

   function automatic logic [31:0] lane_mask(input logic [1:0] size);
      if (size == SZ_BYTE) return BYTE_MASK;
      if (size == SZ_HALF) return HALF_MASK;
      return WORD_MASK;
   endfunction

endpackage

// File: rtl/lane_merge.sv
// Replaces the addressed byte/halfword lane of a memory word with new store data.
module lane_merge
   import mem_pkg::*;
#(
   parameter int unsigned BIG_ENDIAN = 0
) (
   input  logic [31:0] old_word,
   input  logic [31:0] new_data,
   input  logic [1:0]  off,
   input  logic [1:0]  size,
   output logic [31:0] merged
);

   logic [4:0]  shift;
   logic [31:0] mask;

   always_comb begin
      shift  = lane_shift(size, off, BIG_ENDIAN != 0);
      mask   = lane_mask(size);
      merged = (old_word & ~(mask << shift)) | ((new_data & mask) << shift);
   end

endmodule

// File: rtl/mem_access_unit.sv
// Byte/halfword load-store front end for a word-addressed data memory; sub-word
// stores run as a two-cycle read-modify-write that stalls the pipeline.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int unsigned ERR_CNT_W  = 8,
   parameter int unsigned BIG_ENDIAN = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          Add,
   input  logic [31:0]          WData,
   input  logic                 MemRead,
   input  logic                 MemWrite,
   input  logic [1:0]           Size,
   input  logic                 Unsigned,
   output logic [31:0]          RData,
   output logic                 Stall,
   output logic                 AlignErr,
   output logic [ERR_CNT_W-1:0] ErrCount,
   output logic [31:0]          MAdd,
   output logic [31:0]          MWData,
   output logic                 MMemRead,
   output logic                 MMemWrite,
   input  logic [31:0]          MRData
);

   state_t                state_q, state_d;
   logic [31:0]           merge_q, merge_d;
   logic [ERR_CNT_W-1:0]  err_q;
   logic [31:0]           merged;
   logic [31:0]           lane_word;
   logic                  is_byte, is_half, is_word, misal, req;

   lane_merge #(
      .BIG_ENDIAN (BIG_ENDIAN)
   ) u_lane_merge (
      .old_word (MRData),
      .new_data (WData),
      .off      (Add[1:0]),
      .size     (Size),
      .merged   (merged)
   );

   assign is_byte  = (Size == SZ_BYTE);
   assign is_half  = (Size == SZ_HALF);
   assign is_word  = Size[1];
   assign misal    = (is_half && Add[0]) || (is_word && (Add[1:0] != 2'b00));
   assign req      = MemRead || MemWrite;
   assign AlignErr = req && misal;
   assign MAdd     = {Add[31:2], 2'b00};
   assign ErrCount = err_q;
   assign lane_word = MRData >> lane_shift(Size, Add[1:0], BIG_ENDIAN != 0);

   always_comb begin
      state_d   = state_q;
      merge_d   = merge_q;
      Stall     = 1'b0;
      RData     = 32'h0;
      MWData    = 32'h0;
      MMemRead  = 1'b0;
      MMemWrite = 1'b0;
      // Everything is gated by rst so outputs stay quiet while reset is held.
      if (rst) begin
         unique case (state_q)
            S_IDLE: begin
               if (req && !misal) begin
                  if (MemWrite) begin
                     if (is_word) begin
                        MMemWrite = 1'b1;
                        MWData    = WData;
                     end else begin
                        MMemRead = 1'b1;
                        Stall    = 1'b1;
                        merge_d  = merged;
                        state_d  = S_RMW_WR;
                     end
                  end else begin
                     MMemRead = 1'b1;
                     if (is_byte) begin
                        RData = Unsigned ? {24'h0, lane_word[7:0]}
                                         : {{24{lane_word[7]}}, lane_word[7:0]};
                     end else if (is_half) begin
                        RData = Unsigned ? {16'h0, lane_word[15:0]}
                                         : {{16{lane_word[15]}}, lane_word[15:0]};
                     end else begin
                        RData = MRData;
                     end
                  end
               end
            end
            S_RMW_WR: begin
               MMemWrite = 1'b1;
               MWData    = merge_q;
               state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         merge_q <= 32'h0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         merge_q <= merge_d;
         if (state_q == S_IDLE && AlignErr && err_q != '1) begin
            err_q <= err_q + ERR_CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small behavioural word memory.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] Add, WData, RData, MAdd, MWData, MRData;
   logic        MemRead, MemWrite, Unsigned, Stall, AlignErr, MMemRead, MMemWrite;
   logic [1:0]  Size;
   logic [7:0]  ErrCount;
   logic [31:0] mem [0:63];

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   assign MRData = mem[MAdd[7:2]];

   always @(posedge clk) begin
      if (MMemWrite) mem[MAdd[7:2]] <= MWData;
   end

   mem_access_unit #(
      .ERR_CNT_W  (8),
      .BIG_ENDIAN (0)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .Add       (Add),
      .WData     (WData),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .Size      (Size),
      .Unsigned  (Unsigned),
      .RData     (RData),
      .Stall     (Stall),
      .AlignErr  (AlignErr),
      .ErrCount  (ErrCount),
      .MAdd      (MAdd),
      .MWData    (MWData),
      .MMemRead  (MMemRead),
      .MMemWrite (MMemWrite),
      .MRData    (MRData)
   );

   task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] sz, input logic u);
      MemRead = rd; MemWrite = wr; Add = a; WData = d; Size = sz; Unsigned = u;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      drive(1'b0, 1'b1, 32'h11, 32'h5A, 2'b00, 1'b0);
      vectors++;
      if (Stall !== 1'b0) begin
         miscompares++; $display("FAIL reset_stall got %b want 0", Stall);
      end
      vectors++;
      if (MMemRead !== 1'b0 || MMemWrite !== 1'b0) begin
         miscompares++; $display("FAIL reset_mem_en got rd=%b wr=%b want 0 0", MMemRead, MMemWrite);
      end
      vectors++;
      if (RData !== 32'h0 || MWData !== 32'h0) begin
         miscompares++; $display("FAIL reset_data got r=%h w=%h want 0 0", RData, MWData);
      end
      vectors++;
      if (ErrCount !== 8'd0) begin
         miscompares++; $display("FAIL reset_errcnt got %0d want 0", ErrCount);
      end
      drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
      step();
      rst = 1'b1;
      step();
   endtask

   task automatic test_loads();
      mem[4] = 32'h8899AABB;
      drive(1'b1, 1'b0, 32'h13, 32'h0, 2'b00, 1'b0);
      vectors++;
      if (RData !== 32'hFFFFFF88 || Stall !== 1'b0 || MMemRead !== 1'b1) begin
         miscompares++; $display("FAIL lb got %h stall=%b rd=%b want ffffff88 0 1", RData, Stall, MMemRead);
      end
      vectors++;
      if (MAdd !== 32'h10) begin
         miscompares++; $display("FAIL madd got %h want 00000010", MAdd);
      end
      drive(1'b1, 1'b0, 32'h13, 32'h0, 2'b00, 1'b1);
      vectors++;
      if (RData !== 32'h00000088) begin
         miscompares++; $display("FAIL lbu got %h want 00000088", RData);
      end
      drive(1'b1, 1'b0, 32'h10, 32'h0, 2'b01, 1'b0);
      vectors++;
      if (RData !== 32'hFFFFAABB) begin
         miscompares++; $display("FAIL lh got %h want ffffaabb", RData);
      end
      drive(1'b1, 1'b0, 32'h12, 32'h0, 2'b01, 1'b1);
      vectors++;
      if (RData !== 32'h00008899) begin
         miscompares++; $display("FAIL lhu got %h want 00008899", RData);
      end
      drive(1'b0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
      vectors++;
      if (RData !== 32'h0) begin
         miscompares++; $display("FAIL idle_rdata got %h want 0", RData);
      end
      step();
   endtask

   task automatic test_sub_store();
      drive(1'b0, 1'b1, 32'h11, 32'h5A, 2'b00, 1'b0);
      vectors++;
      if (Stall !== 1'b1 || MMemRead !== 1'b1 || MMemWrite !== 1'b0) begin
         miscompares++; $display("FAIL sb_rd got stall=%b rd=%b wr=%b want 1 1 0", Stall, MMemRead, MMemWrite);
      end
      step();
      vectors++;
      if (MMemWrite !== 1'b1 || MWData !== 32'h88995ABB || Stall !== 1'b0 || MMemRead !== 1'b0) begin
         miscompares++; $display("FAIL sb_wr got wr=%b data=%h stall=%b rd=%b want 1 88995abb 0 0", MMemWrite, MWData, Stall, MMemRead);
      end
      step();
      drive(1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
      vectors++;
      if (RData !== 32'h88995ABB || Stall !== 1'b0) begin
         miscompares++; $display("FAIL sb_raw got %h stall=%b want 88995abb 0", RData, Stall);
      end
      step();
      mem[4] = 32'h8899AABB;
      drive(1'b0, 1'b1, 32'h12, 32'h1234, 2'b01, 1'b0);
      vectors++;
      if (Stall !== 1'b1) begin
         miscompares++; $display("FAIL sh_stall got %b want 1", Stall);
      end
      step();
      vectors++;
      if (MMemWrite !== 1'b1 || MWData !== 32'h1234AABB) begin
         miscompares++; $display("FAIL sh_wr got wr=%b data=%h want 1 1234aabb", MMemWrite, MWData);
      end
      step();
      drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
      vectors++;
      if (mem[4] !== 32'h1234AABB) begin
         miscompares++; $display("FAIL sh_mem got %h want 1234aabb", mem[4]);
      end
   endtask

   task automatic test_back_to_back();
      mem[8] = 32'hDEADBEEF;
      drive(1'b0, 1'b1, 32'h21, 32'h11, 2'b00, 1'b0);
      step();
      vectors++;
      if (MWData !== 32'hDEAD11EF || MMemWrite !== 1'b1) begin
         miscompares++; $display("FAIL b2b_first got wr=%b data=%h want 1 dead11ef", MMemWrite, MWData);
      end
      step();
      drive(1'b0, 1'b1, 32'h23, 32'hC3, 2'b00, 1'b0);
      vectors++;
      if (Stall !== 1'b1 || MMemWrite !== 1'b0) begin
         miscompares++; $display("FAIL b2b_second_rd got stall=%b wr=%b want 1 0", Stall, MMemWrite);
      end
      step();
      vectors++;
      if (MWData !== 32'hC3AD11EF) begin
         miscompares++; $display("FAIL b2b_second_wr got %h want c3ad11ef", MWData);
      end
      step();
      drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
      vectors++;
      if (mem[8] !== 32'hC3AD11EF) begin
         miscompares++; $display("FAIL b2b_mem got %h want c3ad11ef", mem[8]);
      end
   endtask

   task automatic test_misaligned();
      logic saw_wr;
      saw_wr = 1'b0;
      mem[1] = 32'h01020304;
      drive(1'b1, 1'b0, 32'h06, 32'h0, 2'b10, 1'b0);
      vectors++;
      if (AlignErr !== 1'b1 || MMemRead !== 1'b0 || RData !== 32'h0 || Stall !== 1'b0) begin
         miscompares++; $display("FAIL lw_misal got err=%b rd=%b data=%h stall=%b want 1 0 0 0", AlignErr, MMemRead, RData, Stall);
      end
      vectors++;
      if (ErrCount !== 8'd0) begin
         miscompares++; $display("FAIL errcnt0 got %0d want 0", ErrCount);
      end
      step();
      vectors++;
      if (ErrCount !== 8'd1) begin
         miscompares++; $display("FAIL errcnt1 got %0d want 1", ErrCount);
      end
      drive(1'b0, 1'b1, 32'h05, 32'hFFFF, 2'b01, 1'b0);
      vectors++;
      if (AlignErr !== 1'b1 || MMemWrite !== 1'b0 || Stall !== 1'b0) begin
         miscompares++; $display("FAIL sh_misal got err=%b wr=%b stall=%b want 1 0 0", AlignErr, MMemWrite, Stall);
      end
      step();
      vectors++;
      if (ErrCount !== 8'd2) begin
         miscompares++; $display("FAIL errcnt2 got %0d want 2", ErrCount);
      end
      for (int i = 0; i < 300; i++) begin
         if (i % 2 == 0) drive(1'b1, 1'b0, 32'h06, 32'h0, 2'b11, 1'b0);
         else drive(1'b0, 1'b1, 32'h05, 32'hFFFF, 2'b01, 1'b0);
         if (MMemWrite) saw_wr = 1'b1;
         step();
      end
      vectors++;
      if (ErrCount !== 8'd255) begin
         miscompares++; $display("FAIL errcnt_sat got %0d want 255", ErrCount);
      end
      vectors++;
      if (saw_wr !== 1'b0 || mem[1] !== 32'h01020304) begin
         miscompares++; $display("FAIL misal_nowrite got saw_wr=%b mem=%h want 0 01020304", saw_wr, mem[1]);
      end
      drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
   endtask

   task automatic test_reset_rmw();
      mem[4] = 32'h8899AABB;
      drive(1'b0, 1'b1, 32'h11, 32'h77, 2'b00, 1'b0);
      step();
      vectors++;
      if (MMemWrite !== 1'b1) begin
         miscompares++; $display("FAIL rst_rmw_pre got wr=%b want 1", MMemWrite);
      end
      #1;
      rst = 1'b0;
      #1;
      vectors++;
      if (MMemWrite !== 1'b0 || Stall !== 1'b0 || ErrCount !== 8'd0) begin
         miscompares++; $display("FAIL rst_rmw_drop got wr=%b stall=%b cnt=%0d want 0 0 0", MMemWrite, Stall, ErrCount);
      end
      drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
      step();
      rst = 1'b1;
      drive(1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
      vectors++;
      if (RData !== 32'h8899AABB || MMemWrite !== 1'b0 || mem[4] !== 32'h8899AABB) begin
         miscompares++; $display("FAIL rst_rmw_idle got data=%h wr=%b mem=%h want 8899aabb 0 8899aabb", RData, MMemWrite, mem[4]);
      end
      step();
   endtask

   task automatic test_rw_both();
      drive(1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 2'b10, 1'b0);
      vectors++;
      if (MMemWrite !== 1'b1 || MWData !== 32'hDEADBEEF || RData !== 32'h0 || Stall !== 1'b0 || MMemRead !== 1'b0) begin
         miscompares++; $display("FAIL sw_both got wr=%b data=%h r=%h stall=%b rd=%b want 1 deadbeef 0 0 0", MMemWrite, MWData, RData, Stall, MMemRead);
      end
      step();
      drive(1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0);
      vectors++;
      if (RData !== 32'hDEADBEEF) begin
         miscompares++; $display("FAIL sw_readback got %h want deadbeef", RData);
      end
      drive(1'b1, 1'b0, 32'h20, 32'h0, 2'b11, 1'b1);
      vectors++;
      if (RData !== 32'hDEADBEEF) begin
         miscompares++; $display("FAIL size11_load got %h want deadbeef", RData);
      end
      drive(1'b1, 1'b0, 32'h22, 32'h0, 2'b11, 1'b0);
      vectors++;
      if (AlignErr !== 1'b1 || RData !== 32'h0) begin
         miscompares++; $display("FAIL size11_misal got err=%b data=%h want 1 0", AlignErr, RData);
      end
      drive(1'b0, 1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
      step();
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      test_reset();
      test_loads();
      test_sub_store();
      test_back_to_back();
      test_misaligned();
      test_reset_rmw();
      test_rw_both();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits between the MEM pipeline stage and the word-addressed data memory. The memory is 32-bit words indexed by Add[15:2], with combinational read under MemRead and a synchronous write at posedge clk.
- Adds byte and halfword loads (sign- or zero-extended) and byte and halfword stores. Sub-word stores are done as a two-cycle read-modify-write that stalls the pipeline.
- Detects misaligned accesses, suppresses them, and counts them.

Parameters:
- ERR_CNT_W, 8, width of the saturating misalignment counter.
- BIG_ENDIAN, 0, byte-lane order. 0: byte 0 is at WData[7:0]. 1: byte 0 is at WData[31:24].

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- Add  input  32  CPU byte address.
- WData  input  32  CPU store data, right-justified.
- MemRead  input  1  CPU load request.
- MemWrite  input  1  CPU store request.
- Size  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- Unsigned  input  1  load extension: 1 zero-extends, 0 sign-extends.
- RData  output  32  extended load result to CPU.
- Stall  output  1  freeze the pipeline. The CPU holds Add, WData, Size and requests stable while this is high.
- AlignErr  output  1  current request is misaligned (combinational).
- ErrCount  output  ERR_CNT_W  saturating count of misaligned requests.
- MAdd  output  32  memory address, always {Add[31:2],2'b00}.
- MWData  output  32  memory write data.
- MMemRead  output  1  memory read enable.
- MMemWrite  output  1  memory write enable.
- MRData  input  32  memory read data (combinational from MAdd).

Behaviour:
- States: IDLE, RMW_WR. Reset (rst=0, asynchronous) sets:
  - state=IDLE, merge register=0, ErrCount=0.
  - Outputs while in reset: Stall=0, MMemWrite=0, MMemRead=0, RData=0, MWData=0.
- Misalignment:
  - Half is misaligned if Add[0]=1.
  - Word is misaligned if Add[1:0]!=0.
  - A misaligned request drives AlignErr=1, MMemRead=0, MMemWrite=0, RData=0 and Stall=0. Nothing is written.
  - ErrCount increments at the clock edge, saturating at all-ones.
  - A request held across a stall is counted once per edge on which it is presented in IDLE.
- Requests where both MemRead and MemWrite are 1 are treated as stores. RData=0 for them.
- Load (IDLE):
  - Drives MMemRead=1 and selects the lane from MRData by Add[1:0] and BIG_ENDIAN.
  - Extends the selected lane per Unsigned and drives RData combinationally.
  - Zero latency, no stall, no state change.
- Word store (IDLE):
  - Drives MMemWrite=1 and MWData=WData in the same cycle.
  - Memory captures the data at that posedge. No stall.
- Sub-word store, IDLE cycle:
  - Drives MMemRead=1 and Stall=1.
  - Merge register <= MRData with the addressed lane(s) replaced by WData[7:0] or WData[15:0].
  - Next state is RMW_WR.
- Sub-word store, RMW_WR cycle:
  - Drives MMemWrite=1, MWData=merge register, MMemRead=0, Stall=0.
  - Next state is IDLE, so the CPU advances on the same edge the memory commits.
  - Total latency is 2 cycles. A back-to-back sub-word store re-enters IDLE and repeats the sequence.
- Read-after-write: a load issued the cycle after RMW_WR sees the merged word, because the memory write has committed.
- RData outside a load cycle is 0.
- Reset asserted during RMW_WR: the state returns to IDLE immediately and MMemWrite deasserts. The store is lost, with no partial write.
- Size=11 behaves exactly as Size=10.

Decomposition:
- Shared package mem_pkg holds:
  - Size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - State encodings S_IDLE, S_RMW_WR.
  - Lane-select helper constants.
- One natural combinational sub-module, lane_merge: takes (old word, new data, Add[1:0], Size) and produces the merged word. The load extractor is inlined.

Test Plan:
- Word at 0x10 preloaded to 0x8899AABB. Loads with BIG_ENDIAN=0, no stall:
  - lb at Add=0x13 -> RData=0xFFFFFF88.
  - lbu at Add=0x13 -> RData=0x00000088.
  - lh at Add=0x10 -> RData=0xFFFFAABB.
- sb WData=0x5A at Add=0x11 over 0x8899AABB:
  - Stall=1 for one cycle.
  - Next cycle MMemWrite=1, MWData=0x88995ABB.
  - A following lw at 0x10 returns 0x88995ABB.
- sh WData=0x1234 at Add=0x12 -> MWData=0x1234AABB after the two-cycle sequence.
- lw at Add=0x06 and sh at Add=0x05:
  - AlignErr=1, MMemWrite never asserted.
  - ErrCount 0->1->2.
  - Drive 300 further misaligned requests -> ErrCount holds at 255.
- Assert rst low during RMW_WR of an sb:
  - MMemWrite drops immediately, state returns to IDLE, Stall=0.
  - Memory word is unchanged.
- sw 0xDEADBEEF at 0x20 with MemRead=1 and MemWrite=1 together:
  - Single-cycle write, RData=0.
  - Next lw at 0x20 returns 0xDEADBEEF.
